cfs_tx_ctrl_pipe: RTL
=====================

// Module: cfs_tx_ctrl_pipe
// PURPOSE
//  Registered TX controller between the TX FIFO pop port and the MD TX interface. A 2-entry
//  skid buffer removes the combinational md_tx_ready->pop_ready path. Optionally discards
//  zero-size entries and flags MD-side stalls. Drop-in successor of the combinational TX controller.
// PARAMETERS
//  ALGN_DATA_WIDTH    32  MD data width in bits; power of 2, >=8
//  DROP_ZERO_SIZE     1   1: popped entries with size==0 are consumed, never sent; 0: sent as-is
//  CNT_WIDTH          16  width of tx_cnt, drop_cnt, stall counter and stall_limit
//  derived: OFFSET_W = (ALGN_DATA_WIDTH<=8) ? 1 : clog2(ALGN_DATA_WIDTH/8)
//           SIZE_W   = clog2(ALGN_DATA_WIDTH/8)+1
//           FIFO_W   = ALGN_DATA_WIDTH+OFFSET_W+SIZE_W
// PORTS
//  clk           in   1          clock, all logic on rising edge
//  reset_n       in   1          reset, synchronous, active-low
//  pop_valid     in   1          TX FIFO has an entry
//  pop_data      in   FIFO_W     {size, offset, data}: data [DW-1:0], offset above it, size on top
//  pop_ready     out  1          entry consumed this cycle when pop_valid & pop_ready
//  md_tx_valid   out  1          MD TX valid
//  md_tx_data    out  DW         MD TX data
//  md_tx_offset  out  OFFSET_W   MD TX byte offset
//  md_tx_size    out  SIZE_W     MD TX size in bytes
//  md_tx_ready   in   1          MD TX ready
//  stall_limit   in   CNT_WIDTH  stall threshold in cycles; 0 disables stall detection
//  stall_event   out  1          1-cycle pulse on stall threshold hit
//  tx_cnt        out  CNT_WIDTH  completed MD transfers, saturating
//  drop_cnt      out  CNT_WIDTH  discarded zero-size entries, saturating
// BEHAVIOUR
//  - Reset (reset_n==0 at posedge, any time incl. mid-transfer): both slots empty,
//    md_tx_valid=0, md_tx_data/offset/size=0, pop_ready=0 during reset then 1,
//    stall_event=0, all counters 0. In-flight entries are lost.
//  - Storage: out slot (drives md_tx_*) + skid slot. pop_ready = !skid_valid (register
//    output only; no combinational dependence on md_tx_ready or pop_valid).
//  - Accept = pop_valid & pop_ready. Accepted entry lands in out slot if out slot empty or
//    draining this cycle, else in skid slot. On out-slot drain with skid full, skid moves to
//    out slot. Strict FIFO order; no entry duplicated or lost.
//  - Latency: accepted at edge N -> md_tx_valid=1 from cycle N+1. Full throughput: 1 entry/cycle
//    sustained while md_tx_ready=1.
//  - MD handshake: transfer when md_tx_valid & md_tx_ready. While valid & !ready, md_tx_*
//    hold stable; valid never drops without a transfer.
//  - Zero-size drop (DROP_ZERO_SIZE=1): accepted entry with size field==0 is not stored;
//    drop_cnt+=1 at same edge. Does not occupy a slot, so it never blocks pop_ready.
//  - tx_cnt+=1 per MD transfer; tx_cnt and drop_cnt saturate at all-ones.
//  - Stall counter: +1 each cycle with md_tx_valid & !md_tx_ready; cleared on any transfer
//    or when md_tx_valid==0. When it reaches stall_limit (!=0), stall_event=1 for exactly one
//    cycle; counter then holds until cleared (no repeat pulse in same stall). Saturates.
//  - stall_limit sampled every cycle; changing it mid-stall compares against the new value.
//  - Simultaneous accept+drain with both slots full impossible (pop_ready=0 when skid full).
// TESTING
//  1 Reset then push 4 entries back-to-back, md_tx_ready=1 -> md_tx_valid from cycle 1,
//    4 consecutive transfers in order, tx_cnt=4, pop_ready stays 1.
//  2 md_tx_ready=0, push 3 entries -> first 2 accepted, pop_ready=0 after 2nd, md_tx_* stable;
//    raise ready -> 3 transfers in order, no gap once skid drained.
//  3 DROP_ZERO_SIZE=1, push sizes {4,0,2} -> MD sees sizes 4,2 only; drop_cnt=1, tx_cnt=2.
//    Repeat with DROP_ZERO_SIZE=0 -> 3 transfers, drop_cnt=0.
//  4 stall_limit=5, hold md_tx_ready=0 for 10 cycles with valid -> stall_event single pulse
//    on 5th stall cycle; stall_limit=0 -> no pulse.
//  5 Assert reset_n=0 for one cycle with both slots full -> next cycle md_tx_valid=0, data 0,
//    counters 0, pop_ready=1; new entry flows with 1-cycle latency.
//  6 Random pop_valid/md_tx_ready (1000 entries, DW=8,32,64) -> scoreboard: order preserved,
//    counts match, no combinational path md_tx_ready->pop_ready (lint/STA check).

Source files
------------

// File: rtl/cfs_tx_ctrl_pipe.sv
// cfs_tx_ctrl_pipe
// Registered TX controller between the TX FIFO pop port and the MD TX interface.
// An out slot drives md_tx_* and a skid slot absorbs one extra entry. Because of
// the skid slot, pop_ready depends only on local state and not on md_tx_ready.
// Zero-size entries can optionally be dropped. A stall detector flags an MD side
// that holds valid data without accepting it for stall_limit cycles.
module cfs_tx_ctrl_pipe #(
   parameter int ALGN_DATA_WIDTH = 32,
   parameter int DROP_ZERO_SIZE  = 1,
   parameter int CNT_WIDTH       = 16,
   localparam int OFFSET_W = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8),
   localparam int SIZE_W   = $clog2(ALGN_DATA_WIDTH / 8) + 1,
   localparam int FIFO_W   = ALGN_DATA_WIDTH + OFFSET_W + SIZE_W
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       pop_valid,
   input  logic [FIFO_W-1:0]          pop_data,
   output logic                       pop_ready,
   output logic                       md_tx_valid,
   output logic [ALGN_DATA_WIDTH-1:0] md_tx_data,
   output logic [OFFSET_W-1:0]        md_tx_offset,
   output logic [SIZE_W-1:0]          md_tx_size,
   input  logic                       md_tx_ready,
   input  logic [CNT_WIDTH-1:0]       stall_limit,
   output logic                       stall_event,
   output logic [CNT_WIDTH-1:0]       tx_cnt,
   output logic [CNT_WIDTH-1:0]       drop_cnt
);

   localparam int                   SIZE_LSB = ALGN_DATA_WIDTH + OFFSET_W;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   logic                 out_valid;
   logic                 skid_valid;
   logic [FIFO_W-1:0]    out_entry;
   logic [FIFO_W-1:0]    skid_entry;
   logic [CNT_WIDTH-1:0] stall_cnt;

   logic accept;
   logic pop_zero;
   logic drop_hit;
   logic store;
   logic xfer;
   logic out_open;
   logic stalling;
   logic limit_hit;
   logic limit_next;

   // Handshake decode. pop_ready is low only while reset is held or the skid slot
   // is occupied, so nothing on the MD side reaches it combinationally.
   assign pop_ready  = reset_n & ~skid_valid;
   assign accept     = pop_valid & pop_ready;
   assign pop_zero   = (pop_data[SIZE_LSB +: SIZE_W] == '0);
   assign drop_hit   = accept & pop_zero & (DROP_ZERO_SIZE != 0);
   assign store      = accept & ~drop_hit;
   assign xfer       = out_valid & md_tx_ready;
   assign out_open   = ~out_valid | xfer;
   assign stalling   = out_valid & ~md_tx_ready;
   assign limit_hit  = (stall_limit != '0) && (stall_cnt == stall_limit);
   assign limit_next = (stall_limit != '0) && ((stall_cnt + CNT_ONE) == stall_limit);

   assign md_tx_valid  = out_valid;
   assign md_tx_data   = out_entry[ALGN_DATA_WIDTH-1:0];
   assign md_tx_offset = out_entry[ALGN_DATA_WIDTH +: OFFSET_W];
   assign md_tx_size   = out_entry[SIZE_LSB +: SIZE_W];

   // Slot management. When the out slot is free or draining, it takes the skid entry
   // first to keep FIFO order, otherwise the new entry. The skid slot only fills when
   // the out slot is held by a stalled MD side. Pop is blocked while skid is full, so
   // a refill from skid and a new store never happen in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         out_entry  <= '0;
         skid_entry <= '0;
      end else if (out_open) begin
         if (skid_valid) begin
            out_entry  <= skid_entry;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else if (store) begin
            out_entry <= pop_data;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (store) begin
         skid_entry <= pop_data;
         skid_valid <= 1'b1;
      end
   end

   // Saturating counters of completed MD transfers and discarded zero-size entries.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_cnt   <= '0;
         drop_cnt <= '0;
      end else begin
         if (xfer && (tx_cnt != CNT_MAX)) begin
            tx_cnt <= tx_cnt + CNT_ONE;
         end
         if (drop_hit && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + CNT_ONE;
         end
      end
   end

   // Stall detector. It counts stalled cycles and pulses stall_event once when the
   // count reaches the current stall_limit. The count then freezes at the limit, so
   // the same stall cannot pulse again. Any transfer or idle cycle clears the count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_cnt   <= '0;
         stall_event <= 1'b0;
      end else if (!stalling) begin
         stall_cnt   <= '0;
         stall_event <= 1'b0;
      end else begin
         if (!limit_hit && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         stall_event <= !limit_hit && limit_next;
      end
   end

endmodule
